// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared RAM port arbiter between imem fetch and dmem load/store
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic            dreq;
    logic            i_done;
    logic            d_done;

    assign dreq  = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

    // Grant state register; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration, RAM drive and completion; addr/data follow the owner live.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && iREN && (starve_cnt == STARVE_LIM)) begin
                    next_state = IGRANT;
                end else if (dreq) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        iwait      = 1'b0;
                        i_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dwait      = 1'b0;
                        d_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Count dmem wins while imem is waiting so imem cannot be starved.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!iREN || i_done) begin
            starve_cnt <= '0;
        end else if (d_done && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Sticky RAM error flag, only a reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ram_err <= 1'b0;
        end else if ((state != IDLE) && (ramstate == RAM_ERROR)) begin
            ram_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST     = 1'b0;
        iREN     = 1'b1;
        iaddr    = 32'h40;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        ramload  = 32'hDEADBEEF;
        ramstate = FREE;

        // reset with imem requesting
        #2;
        chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_ram_err", {31'b0, ram_err}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        tick();
        tick();
        nRST = 1'b1;
        #1;
        chk("rel_idle_ramREN", {31'b0, ramREN}, 32'd0);

        // first cycle after release: IGRANT
        tick();
        chk("ig_ramREN", {31'b0, ramREN}, 32'd1);
        chk("ig_ramaddr", ramaddr, 32'h40);
        ramstate = BUSY;
        #1;
        chk("ig_busy1_iwait", {31'b0, iwait}, 32'd1);
        tick();
        chk("ig_busy2_iwait", {31'b0, iwait}, 32'd1);
        chk("ig_busy2_ramREN", {31'b0, ramREN}, 32'd1);
        tick();
        ramstate = ACCESS;
        #1;
        chk("ig_done_iwait", {31'b0, iwait}, 32'd0);
        chk("ig_done_iload", iload, 32'hDEADBEEF);
        chk("ig_done_dwait", {31'b0, dwait}, 32'd1);
        tick();
        ramstate = FREE;
        #1;
        chk("ig_idle_iwait", {31'b0, iwait}, 32'd1);
        chk("ig_idle_ramREN", {31'b0, ramREN}, 32'd0);
        iREN = 1'b0;
        tick();
        chk("quiet_ramREN", {31'b0, ramREN}, 32'd0);

        // simultaneous imem read and dmem write: dmem first
        iREN   = 1'b1;
        iaddr  = 32'h80;
        dWEN   = 1'b1;
        daddr  = 32'h100;
        dstore = 32'h1234;
        tick();
        chk("dw_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("dw_ramREN", {31'b0, ramREN}, 32'd0);
        chk("dw_ramaddr", ramaddr, 32'h100);
        chk("dw_ramstore", ramstore, 32'h1234);
        chk("dw_iwait", {31'b0, iwait}, 32'd1);
        ramstate = ACCESS;
        #1;
        chk("dw_done_dwait", {31'b0, dwait}, 32'd0);
        tick();
        dWEN     = 1'b0;
        ramstate = FREE;
        #1;
        chk("dw_idle_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("dw_idle_ramREN", {31'b0, ramREN}, 32'd0);
        chk("dw_cnt1", {29'b0, dut.starve_cnt}, 32'd1);
        tick();
        chk("dw_then_ig_ramREN", {31'b0, ramREN}, 32'd1);
        chk("dw_then_ig_ramaddr", ramaddr, 32'h80);
        ramstate = ACCESS;
        #1;
        chk("dw_then_ig_iwait", {31'b0, iwait}, 32'd0);
        tick();
        iREN     = 1'b0;
        ramstate = FREE;
        #1;
        chk("dw_cnt_clr", {29'b0, dut.starve_cnt}, 32'd0);
        tick();

        // starvation guard: iREN held, dREN keeps requesting
        iREN    = 1'b1;
        iaddr   = 32'h44;
        dREN    = 1'b1;
        daddr   = 32'h200;
        ramload = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sv_dgrant_addr", ramaddr, 32'h200);
            chk("sv_dgrant_ren", {31'b0, ramREN}, 32'd1);
            ramstate = ACCESS;
            #1;
            chk("sv_dgrant_dwait", {31'b0, dwait}, 32'd0);
            chk("sv_dgrant_dload", dload, 32'hCAFEF00D);
            tick();
            ramstate = FREE;
            #1;
            chk("sv_cnt", {29'b0, dut.starve_cnt}, 32'(k + 1));
        end
        tick();
        chk("sv_forced_ig_addr", ramaddr, 32'h44);
        chk("sv_forced_ig_dwait", {31'b0, dwait}, 32'd1);
        ramstate = ACCESS;
        #1;
        chk("sv_forced_ig_iwait", {31'b0, iwait}, 32'd0);
        tick();
        ramstate = FREE;
        #1;
        chk("sv_cnt_zero", {29'b0, dut.starve_cnt}, 32'd0);
        tick();
        chk("sv_fifth_dgrant_addr", ramaddr, 32'h200);
        ramstate = ACCESS;
        #1;
        chk("sv_fifth_dwait", {31'b0, dwait}, 32'd0);
        tick();
        ramstate = FREE;
        #1;
        chk("sv_cnt_one", {29'b0, dut.starve_cnt}, 32'd1);
        tick();
        chk("sv_sixth_dgrant_addr", ramaddr, 32'h200);
        ramstate = ACCESS;
        #1;
        chk("sv_sixth_dwait", {31'b0, dwait}, 32'd0);
        tick();
        dREN     = 1'b0;
        iREN     = 1'b0;
        ramstate = FREE;
        tick();

        // dmem request dropped mid-grant
        dREN  = 1'b1;
        daddr = 32'h300;
        tick();
        ramstate = BUSY;
        #1;
        chk("drop_busy_ramREN", {31'b0, ramREN}, 32'd1);
        tick();
        dREN = 1'b0;
        #1;
        chk("drop_ramREN", {31'b0, ramREN}, 32'd0);
        chk("drop_dwait", {31'b0, dwait}, 32'd1);
        tick();
        dREN = 1'b1;
        #1;
        chk("drop_idle_ramREN", {31'b0, ramREN}, 32'd0);
        tick();
        chk("regrant_ramREN", {31'b0, ramREN}, 32'd1);

        // RAM error during DGRANT
        ramstate = ERROR;
        #1;
        chk("err_dwait", {31'b0, dwait}, 32'd1);
        chk("err_not_yet", {31'b0, ram_err}, 32'd0);
        tick();
        chk("err_set", {31'b0, ram_err}, 32'd1);
        chk("err_hold_ramREN", {31'b0, ramREN}, 32'd1);
        ramstate = ACCESS;
        #1;
        chk("err_access_dwait", {31'b0, dwait}, 32'd0);
        tick();
        ramstate = FREE;
        #1;
        chk("err_sticky", {31'b0, ram_err}, 32'd1);

        // reset asserted mid-transaction
        tick();
        chk("pre_rst_ramREN", {31'b0, ramREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("mid_rst_dwait", {31'b0, dwait}, 32'd1);
        chk("mid_rst_ram_err", {31'b0, ram_err}, 32'd0);
        dREN = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
